cosine_streamer: RTL

COSINE_STREAMER -- requirements
Module: cosine_streamer

---
 rtl/cosine_pkg.sv | 7 +
 rtl/cosine_skid_fifo.sv | 38 +++
 rtl/cosine_streamer.sv | 90 +++++++++
 3 files changed

// File: rtl/cosine_pkg.sv
// cosine_pkg: shared defaults and FSM state type for the cosine streamer
package cosine_pkg;
  localparam int ROM_AW_DEF = 7;
  localparam int ROM_DW_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/cosine_skid_fifo.sv
// cosine_skid_fifo: 2-entry buffer decoupling table reads from the sample stream
module cosine_skid_fifo #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic [1:0]    count_o
);
  logic [DW-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  assign data_o = mem[rd_ptr];
  // storage and pointers; flush empties without touching stored data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count_o <= 2'd0;
    end else if (flush_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count_o <= 2'd0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr <= ~wr_ptr;
      end
      if (pop_i) rd_ptr <= ~rd_ptr;
      count_o <= count_o + 2'(push_i) - 2'(pop_i);
    end
  end
endmodule

// File: rtl/cosine_streamer.sv
// cosine_streamer: streams a burst of cosine table samples with phase stepping
module cosine_streamer import cosine_pkg::*; #(
  parameter int ROM_AW = ROM_AW_DEF,
  parameter int ROM_DW = ROM_DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ROM_AW-1:0] phase_init_i,
  input  logic [ROM_AW-1:0] phase_inc_i,
  input  logic [CNT_W-1:0]  n_samples_i,
  input  logic              abort_i,
  output logic              rom_cen_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [ROM_DW-1:0] rom_data_i,
  output logic [ROM_DW-1:0] samp_data_o,
  output logic              samp_valid_o,
  input  logic              samp_ready_i,
  output logic              busy_o,
  output logic              done_o
);
  state_t state, state_nx;
  logic [ROM_AW-1:0] acc, inc;
  logic [CNT_W-1:0] n, cnt;
  logic in_flight, room, pop;
  logic [1:0] count;
  assign pop = samp_valid_o & samp_ready_i;
  assign room = 3'(count) + 3'(in_flight) < 3'd2 + 3'(pop);
  assign samp_valid_o = count != 2'd0;
  assign busy_o = state != IDLE;
  assign rom_addr_o = acc;
  // state register
  always_ff @(posedge clk_i) state <= !rst_ni ? IDLE : state_nx;
  // next state, read issue and end-of-burst pulse; abort overrides everything
  always_comb begin
    state_nx = state;
    rom_cen_o = 1'b0;
    done_o = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = n_samples_i == '0 ? DRAIN : RUN;
      RUN: begin
        if (abort_i) state_nx = IDLE;
        else if (room) begin
          rom_cen_o = 1'b1;
          if (cnt == n - CNT_W'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) state_nx = IDLE;
        else if (count == 2'd0 && !in_flight) begin
          done_o = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // burst parameters, phase accumulator, read counter and in-flight flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc <= '0;
      inc <= '0;
      n <= '0;
      cnt <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rom_cen_o;
      if (state == IDLE && start_i) begin
        acc <= phase_init_i;
        inc <= phase_inc_i;
        n <= n_samples_i;
        cnt <= '0;
      end else if (rom_cen_o) begin
        acc <= acc + inc;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
  cosine_skid_fifo #(.DW(ROM_DW)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(abort_i & busy_o),
    .push_i(in_flight),
    .pop_i(pop),
    .data_i(rom_data_i),
    .data_o(samp_data_o),
    .count_o(count)
  );
endmodule
